bakraid_gp9001_bus: RTL and testbench

- CPU-side bus sequencer that sits directly upstream of the bakraid_video GP9001 port.
- Turns 68000 accesses to the GP9001 window and the object-bank window into the GCU handshake: GP9001CS, one GP9001_OP_* strobe, and a wait for GP9001ACK.
- Returns read data and status words, and generates CPU_DTACKn.
- Splits a full-word VRAM read into two byte-lane GCU reads, H then L.

---
 rtl/bakraid_gp9001_pkg.sv | 43 ++++
 rtl/bakraid_gp9001_opdec.sv | 34 +++
 rtl/bakraid_gp9001_bus.sv | 192 +++++++++++++++++++
 tb/tb_bakraid_gp9001_bus.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bakraid_gp9001_pkg.sv
// Shared definitions for the bakraid GP9001 CPU bus sequencer:
// FSM states, op one-hot indices, address offsets, status bit positions.
package bakraid_gp9001_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACK,
      ST_RELEASE,
      ST_DTACK
   } state_t;

   localparam int OP_W              = 7;
   localparam int OP_SELECT_REG     = 0;
   localparam int OP_WRITE_REG      = 1;
   localparam int OP_WRITE_RAM      = 2;
   localparam int OP_READ_RAM_H     = 3;
   localparam int OP_READ_RAM_L     = 4;
   localparam int OP_SET_RAM_PTR    = 5;
   localparam int OP_OBJECTBANK_WR  = 6;

   localparam logic [1:0] ADDR_RAM_PTR  = 2'd0;
   localparam logic [1:0] ADDR_RAM_DATA = 2'd1;
   localparam logic [1:0] ADDR_REG_SEL  = 2'd2;
   localparam logic [1:0] ADDR_REG_DATA = 2'd3;

   localparam int STAT_HSYNC  = 0;
   localparam int STAT_VSYNC  = 8;
   localparam int STAT_FBLANK = 15;

   function automatic logic [15:0] status_word(input logic hs,
                                               input logic vs,
                                               input logic fb,
                                               input logic inv);
      logic [15:0] w;
      w = '0;
      w[STAT_HSYNC]  = hs ^ inv;
      w[STAT_VSYNC]  = vs ^ inv;
      w[STAT_FBLANK] = fb ^ inv;
      return w;
   endfunction

endpackage

// File: rtl/bakraid_gp9001_opdec.sv
// Combinational decode of a CPU access into a GCU op one-hot.
// A VRAM read is reported on the READ_RAM_H bit; lanes are resolved upstream.
module bakraid_gp9001_opdec
   import bakraid_gp9001_pkg::*;
(
   input  logic            sel,
   input  logic            objbank_sel,
   input  logic [2:0]      addr,
   input  logic            rnw,
   output logic [OP_W-1:0] op,
   output logic            need_gcu,
   output logic            is_status
);

   always_comb begin
      op        = '0;
      is_status = 1'b0;
      if (sel) begin
         unique case (addr[1:0])
            ADDR_RAM_PTR:  op[OP_SET_RAM_PTR] = ~rnw;
            ADDR_RAM_DATA: op[rnw ? OP_READ_RAM_H : OP_WRITE_RAM] = 1'b1;
            ADDR_REG_SEL:  op[OP_SELECT_REG] = ~rnw;
            ADDR_REG_DATA: begin
               is_status        = rnw;
               op[OP_WRITE_REG] = ~rnw;
            end
         endcase
      end else if (objbank_sel) begin
         op[OP_OBJECTBANK_WR] = ~rnw;
      end
      need_gcu = |op;
   end

endmodule

// File: rtl/bakraid_gp9001_bus.sv
// 68000-to-GP9001 GCU handshake sequencer with DTACK generation.
// Optional ACK timeout: define BAKRAID_GP9001_TIMEOUT_EN.
module bakraid_gp9001_bus
   import bakraid_gp9001_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter bit STATUS_INV     = 1'b0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [2:0]  CPU_ADDR,
   input  logic [15:0] CPU_DIN,
   output logic [15:0] CPU_DOUT,
   input  logic        CPU_RNW,
   input  logic        CPU_UDSn,
   input  logic        CPU_LDSn,
   input  logic        GP9001_SEL,
   input  logic        OBJBANK_SEL,
   output logic        CPU_DTACKn,
   output logic        GP9001CS,
   input  logic        GP9001ACK,
   output logic [15:0] GP9001DIN,
   input  logic [15:0] GP9001DOUT,
   output logic        GP9001_OP_SELECT_REG,
   output logic        GP9001_OP_WRITE_REG,
   output logic        GP9001_OP_WRITE_RAM,
   output logic        GP9001_OP_READ_RAM_H,
   output logic        GP9001_OP_READ_RAM_L,
   output logic        GP9001_OP_SET_RAM_PTR,
   output logic        GP9001_OP_OBJECTBANK_WR,
   output logic [2:0]  GP9001_OBJECTBANK_SLOT,
   input  logic        CPU_HSYNC,
   input  logic        CPU_VSYNC,
   input  logic        CPU_FBLANK
);

   state_t          state_q, state_d;
   logic [OP_W-1:0] cur_op_q, cur_op_d;
   logic [OP_W-1:0] op_q, op_d;
   logic [OP_W-1:0] dec_op;
   logic            dec_need, dec_status;
   logic            cs_q, cs_d;
   logic            dtackn_q, dtackn_d;
   logic            pend_l_q, pend_l_d;
   logic [15:0]     din_q, din_d;
   logic [15:0]     dout_q, dout_d;
   logic [2:0]      slot_q, slot_d;
   logic            sel_any, ds_any, rd_op;

`ifdef BAKRAID_GP9001_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                       $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CW-1:0] cnt_q, cnt_d;
`else
   logic tmo_unused;
   assign tmo_unused = |TIMEOUT_CYCLES;
`endif

   bakraid_gp9001_opdec u_opdec (
      .sel         (GP9001_SEL),
      .objbank_sel (OBJBANK_SEL),
      .addr        (CPU_ADDR),
      .rnw         (CPU_RNW),
      .op          (dec_op),
      .need_gcu    (dec_need),
      .is_status   (dec_status)
   );

   assign sel_any = GP9001_SEL | OBJBANK_SEL;
   assign ds_any  = ~CPU_UDSn | ~CPU_LDSn;
   assign rd_op   = cur_op_q[OP_READ_RAM_H] | cur_op_q[OP_READ_RAM_L];

   always_comb begin
      state_d  = state_q;
      cur_op_d = cur_op_q;
      pend_l_d = pend_l_q;
      din_d    = din_q;
      dout_d   = dout_q;
      slot_d   = slot_q;
      dtackn_d = 1'b1;
`ifdef BAKRAID_GP9001_TIMEOUT_EN
      cnt_d    = '0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (sel_any && ds_any) begin
               din_d = CPU_DIN;
               if (dec_need) begin
                  cur_op_d = dec_op;
                  // LDS-only VRAM read goes straight to the low half
                  if (dec_op[OP_READ_RAM_H] && CPU_UDSn) begin
                     cur_op_d                = '0;
                     cur_op_d[OP_READ_RAM_L] = 1'b1;
                  end
                  pend_l_d = dec_op[OP_READ_RAM_H] & ~CPU_UDSn & ~CPU_LDSn;
                  dout_d   = '0;
                  if (dec_op[OP_OBJECTBANK_WR]) slot_d = CPU_ADDR;
                  state_d  = ST_ISSUE;
               end else begin
                  dout_d  = dec_status ?
                     status_word(CPU_HSYNC, CPU_VSYNC, CPU_FBLANK, STATUS_INV) :
                     16'h0000;
                  state_d = ST_DTACK;
               end
            end
         end
         ST_ISSUE: state_d = ST_WAIT_ACK;
         ST_WAIT_ACK: begin
            if (GP9001ACK) begin
               if (cur_op_q[OP_READ_RAM_H]) dout_d[15:8] = GP9001DOUT[15:8];
               if (cur_op_q[OP_READ_RAM_L]) dout_d[7:0]  = GP9001DOUT[7:0];
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!GP9001ACK) begin
               if (pend_l_q) begin
                  pend_l_d                = 1'b0;
                  cur_op_d                = '0;
                  cur_op_d[OP_READ_RAM_L] = 1'b1;
                  state_d                 = ST_ISSUE;
               end else begin
                  state_d = sel_any ? ST_DTACK : ST_IDLE;
               end
            end
         end
         ST_DTACK: begin
            if (!sel_any) state_d  = ST_IDLE;
            else          dtackn_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
`ifdef BAKRAID_GP9001_TIMEOUT_EN
      if (state_q == ST_WAIT_ACK || state_q == ST_RELEASE) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            pend_l_d = 1'b0;
            if (rd_op) dout_d = 16'hFFFF;
            state_d  = ST_DTACK;
         end
      end
`endif
      // CS and strobe are registered images of the next state
      cs_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK);
      op_d = cs_d ? cur_op_d : '0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         cur_op_q <= '0;
         op_q     <= '0;
         cs_q     <= 1'b0;
         dtackn_q <= 1'b1;
         pend_l_q <= 1'b0;
         din_q    <= '0;
         dout_q   <= '0;
         slot_q   <= '0;
      end else begin
         state_q  <= state_d;
         cur_op_q <= cur_op_d;
         op_q     <= op_d;
         cs_q     <= cs_d;
         dtackn_q <= dtackn_d;
         pend_l_q <= pend_l_d;
         din_q    <= din_d;
         dout_q   <= dout_d;
         slot_q   <= slot_d;
      end
   end

`ifdef BAKRAID_GP9001_TIMEOUT_EN
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end
`endif

   assign CPU_DOUT                = dout_q;
   assign CPU_DTACKn              = dtackn_q;
   assign GP9001CS                = cs_q;
   assign GP9001DIN               = din_q;
   assign GP9001_OBJECTBANK_SLOT  = slot_q;
   assign GP9001_OP_SELECT_REG    = op_q[OP_SELECT_REG];
   assign GP9001_OP_WRITE_REG     = op_q[OP_WRITE_REG];
   assign GP9001_OP_WRITE_RAM     = op_q[OP_WRITE_RAM];
   assign GP9001_OP_READ_RAM_H    = op_q[OP_READ_RAM_H];
   assign GP9001_OP_READ_RAM_L    = op_q[OP_READ_RAM_L];
   assign GP9001_OP_SET_RAM_PTR   = op_q[OP_SET_RAM_PTR];
   assign GP9001_OP_OBJECTBANK_WR = op_q[OP_OBJECTBANK_WR];

endmodule

// File: tb/tb_bakraid_gp9001_bus.sv
// Directed self-checking bench for bakraid_gp9001_bus.
// A small GCU responder raises ACK one cycle into each request.
module tb_bakraid_gp9001_bus;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [2:0]  CPU_ADDR;
   logic [15:0] CPU_DIN;
   logic [15:0] CPU_DOUT;
   logic        CPU_RNW;
   logic        CPU_UDSn;
   logic        CPU_LDSn;
   logic        GP9001_SEL;
   logic        OBJBANK_SEL;
   logic        CPU_DTACKn;
   logic        GP9001CS;
   logic        GP9001ACK;
   logic [15:0] GP9001DIN;
   logic [15:0] GP9001DOUT;
   logic        op_sel, op_wreg, op_wram, op_rh, op_rl, op_ptr, op_obj;
   logic [2:0]  SLOT;
   logic        CPU_HSYNC, CPU_VSYNC, CPU_FBLANK;

   bakraid_gp9001_bus dut (
      .CLK                     (CLK),
      .RESET                   (RESET),
      .CPU_ADDR                (CPU_ADDR),
      .CPU_DIN                 (CPU_DIN),
      .CPU_DOUT                (CPU_DOUT),
      .CPU_RNW                 (CPU_RNW),
      .CPU_UDSn                (CPU_UDSn),
      .CPU_LDSn                (CPU_LDSn),
      .GP9001_SEL              (GP9001_SEL),
      .OBJBANK_SEL             (OBJBANK_SEL),
      .CPU_DTACKn              (CPU_DTACKn),
      .GP9001CS                (GP9001CS),
      .GP9001ACK               (GP9001ACK),
      .GP9001DIN               (GP9001DIN),
      .GP9001DOUT              (GP9001DOUT),
      .GP9001_OP_SELECT_REG    (op_sel),
      .GP9001_OP_WRITE_REG     (op_wreg),
      .GP9001_OP_WRITE_RAM     (op_wram),
      .GP9001_OP_READ_RAM_H    (op_rh),
      .GP9001_OP_READ_RAM_L    (op_rl),
      .GP9001_OP_SET_RAM_PTR   (op_ptr),
      .GP9001_OP_OBJECTBANK_WR (op_obj),
      .GP9001_OBJECTBANK_SLOT  (SLOT),
      .CPU_HSYNC               (CPU_HSYNC),
      .CPU_VSYNC               (CPU_VSYNC),
      .CPU_FBLANK              (CPU_FBLANK)
   );

   always #5 CLK = ~CLK;

   // index: 0 SELREG 1 WREG 2 WRAM 3 RDH 4 RDL 5 PTR 6 OBJ
   logic [6:0] stb;
   assign stb = {op_obj, op_ptr, op_rl, op_rh, op_wram, op_wreg, op_sel};

   int          cmp_cnt = 0;
   int          fail_cnt = 0;
   logic        ack_en = 1'b1;
   logic [15:0] rd_h = 16'h0000;
   logic [15:0] rd_l = 16'h0000;
   int          cs_cnt = 0;

   int          stb_cyc [7];
   int          stb_sum;
   int          dt_cyc;
   logic [15:0] dout_dt;
   logic        gap_ok;

   always @(posedge CLK) begin
      #1;
      if (GP9001CS) cs_cnt++;
      else          cs_cnt = 0;
      GP9001ACK  = ack_en && GP9001CS && (cs_cnt > 1);
      GP9001DOUT = op_rh ? rd_h : rd_l;
   end

   task automatic idle_bus();
      GP9001_SEL  = 1'b0;
      OBJBANK_SEL = 1'b0;
      CPU_UDSn    = 1'b1;
      CPU_LDSn    = 1'b1;
      CPU_RNW     = 1'b1;
   endtask

   // Drives one access for ncyc cycles, recording per-cycle strobe activity,
   // the first DTACKn-low cycle and DOUT at that cycle, then releases the bus.
   task automatic run_access(input logic [2:0] a, input logic rnw,
                             input logic udsn, input logic ldsn,
                             input logic [15:0] d, input logic gs,
                             input logic os, input int ncyc);
      logic h_seen, ack_low, l_started;
      @(posedge CLK);
      #1;
      CPU_ADDR = a; CPU_RNW = rnw; CPU_UDSn = udsn; CPU_LDSn = ldsn;
      CPU_DIN = d; GP9001_SEL = gs; OBJBANK_SEL = os;
      for (int k = 0; k < 7; k++) stb_cyc[k] = 0;
      dt_cyc = -1; dout_dt = '0; gap_ok = 1'b0;
      h_seen = 1'b0; ack_low = 1'b0; l_started = 1'b0;
      for (int n = 1; n <= ncyc; n++) begin
         @(posedge CLK);
         @(negedge CLK);
         for (int k = 0; k < 7; k++) stb_cyc[k] += int'(stb[k]);
         if (stb[3]) h_seen = 1'b1;
         else if (h_seen && !GP9001ACK) ack_low = 1'b1;
         if (stb[4] && !l_started) begin
            l_started = 1'b1;
            gap_ok    = h_seen && ack_low;
         end
         if (!CPU_DTACKn && dt_cyc < 0) begin
            dt_cyc  = n;
            dout_dt = CPU_DOUT;
         end
      end
      stb_sum = 0;
      for (int k = 0; k < 7; k++) stb_sum += stb_cyc[k];
      idle_bus();
      @(posedge CLK);
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      cmp_cnt++;
      if (CPU_DTACKn !== 1'b1) begin
         fail_cnt++; $display("FAIL reset_dtackn got %b want 1", CPU_DTACKn);
      end
      cmp_cnt++;
      if (GP9001CS !== 1'b0) begin
         fail_cnt++; $display("FAIL reset_cs got %b want 0", GP9001CS);
      end
      cmp_cnt++;
      if (stb !== 7'h00) begin
         fail_cnt++; $display("FAIL reset_strobes got %h want 00", stb);
      end
      cmp_cnt++;
      if (CPU_DOUT !== 16'h0000) begin
         fail_cnt++; $display("FAIL reset_dout got %h want 0000", CPU_DOUT);
      end
      cmp_cnt++;
      if (GP9001DIN !== 16'h0000) begin
         fail_cnt++; $display("FAIL reset_din got %h want 0000", GP9001DIN);
      end
      cmp_cnt++;
      if (SLOT !== 3'd0) begin
         fail_cnt++; $display("FAIL reset_slot got %0d want 0", SLOT);
      end
      @(posedge CLK);
      #1 RESET = 1'b0;
   endtask

   task automatic test_write_select_reg();
      run_access(3'd2, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (stb_cyc[0] !== 2) begin
         fail_cnt++; $display("FAIL selreg_cycles got %0d want 2", stb_cyc[0]);
      end
      cmp_cnt++;
      if (stb_sum !== 2) begin
         fail_cnt++; $display("FAIL selreg_only got %0d want 2", stb_sum);
      end
      cmp_cnt++;
      if (GP9001DIN !== 16'h0003) begin
         fail_cnt++; $display("FAIL selreg_din got %h want 0003", GP9001DIN);
      end
      cmp_cnt++;
      if (dt_cyc !== 5) begin
         fail_cnt++; $display("FAIL selreg_dtack got %0d want 5", dt_cyc);
      end
      cmp_cnt++;
      if (CPU_DTACKn !== 1'b1) begin
         fail_cnt++; $display("FAIL selreg_dtack_rel got %b want 1", CPU_DTACKn);
      end
   endtask

   task automatic test_word_read();
      rd_h = 16'hAB00; rd_l = 16'h00CD;
      run_access(3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (stb_cyc[3] !== 2 || stb_cyc[4] !== 2) begin
         fail_cnt++;
         $display("FAIL word_halves got H=%0d L=%0d want 2 2",
                  stb_cyc[3], stb_cyc[4]);
      end
      cmp_cnt++;
      if (gap_ok !== 1'b1) begin
         fail_cnt++; $display("FAIL word_ack_gap got %b want 1", gap_ok);
      end
      cmp_cnt++;
      if (dout_dt !== 16'hABCD) begin
         fail_cnt++; $display("FAIL word_dout got %h want abcd", dout_dt);
      end
      cmp_cnt++;
      if (dt_cyc !== 8) begin
         fail_cnt++; $display("FAIL word_dtack got %0d want 8", dt_cyc);
      end
   endtask

   task automatic test_status();
      CPU_HSYNC = 1'b1; CPU_VSYNC = 1'b1; CPU_FBLANK = 1'b0;
      run_access(3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6);
      cmp_cnt++;
      if (dout_dt !== 16'h0101) begin
         fail_cnt++; $display("FAIL status_a got %h want 0101", dout_dt);
      end
      cmp_cnt++;
      if (dt_cyc !== 2) begin
         fail_cnt++; $display("FAIL status_dtack got %0d want 2", dt_cyc);
      end
      cmp_cnt++;
      if (stb_sum !== 0) begin
         fail_cnt++; $display("FAIL status_nostrobe got %0d want 0", stb_sum);
      end
      CPU_HSYNC = 1'b0; CPU_VSYNC = 1'b0; CPU_FBLANK = 1'b1;
      run_access(3'd7, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 6);
      cmp_cnt++;
      if (dout_dt !== 16'h8000) begin
         fail_cnt++; $display("FAIL status_b_mirror got %h want 8000", dout_dt);
      end
   endtask

   task automatic test_zero_reads();
      run_access(3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6);
      cmp_cnt++;
      if (dout_dt !== 16'h0000 || dt_cyc !== 2 || stb_sum !== 0) begin
         fail_cnt++;
         $display("FAIL zero_addr0 got %h dt=%0d stb=%0d want 0000 2 0",
                  dout_dt, dt_cyc, stb_sum);
      end
      CPU_HSYNC = 1'b1;
      run_access(3'd3, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 6);
      cmp_cnt++;
      if (dout_dt !== 16'h0000 || dt_cyc !== 2 || stb_sum !== 0) begin
         fail_cnt++;
         $display("FAIL zero_objbank got %h dt=%0d stb=%0d want 0000 2 0",
                  dout_dt, dt_cyc, stb_sum);
      end
   endtask

   task automatic test_byte_lanes();
      rd_h = 16'hAB5A; rd_l = 16'h3CCD;
      run_access(3'd1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (dout_dt !== 16'hAB00 || stb_cyc[3] !== 2 || stb_cyc[4] !== 0) begin
         fail_cnt++;
         $display("FAIL lane_upper got %h H=%0d L=%0d want ab00 2 0",
                  dout_dt, stb_cyc[3], stb_cyc[4]);
      end
      run_access(3'd1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (dout_dt !== 16'h00CD || stb_cyc[3] !== 0 || stb_cyc[4] !== 2) begin
         fail_cnt++;
         $display("FAIL lane_lower got %h H=%0d L=%0d want 00cd 0 2",
                  dout_dt, stb_cyc[3], stb_cyc[4]);
      end
   endtask

   task automatic test_objbank_write();
      run_access(3'd5, 1'b0, 1'b0, 1'b0, 16'h0012, 1'b0, 1'b1, 12);
      cmp_cnt++;
      if (stb_cyc[6] !== 2 || stb_sum !== 2) begin
         fail_cnt++;
         $display("FAIL objbank_strobe got %0d/%0d want 2/2",
                  stb_cyc[6], stb_sum);
      end
      cmp_cnt++;
      if (SLOT !== 3'd5) begin
         fail_cnt++; $display("FAIL objbank_slot got %0d want 5", SLOT);
      end
      cmp_cnt++;
      if (GP9001DIN !== 16'h0012) begin
         fail_cnt++; $display("FAIL objbank_din got %h want 0012", GP9001DIN);
      end
      cmp_cnt++;
      if (dt_cyc !== 5) begin
         fail_cnt++; $display("FAIL objbank_dtack got %0d want 5", dt_cyc);
      end
   endtask

   task automatic test_priority();
      run_access(3'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b1, 1'b1, 12);
      cmp_cnt++;
      if (stb_cyc[5] !== 2 || stb_cyc[6] !== 0) begin
         fail_cnt++;
         $display("FAIL prio_op got ptr=%0d obj=%0d want 2 0",
                  stb_cyc[5], stb_cyc[6]);
      end
      cmp_cnt++;
      if (SLOT !== 3'd5) begin
         fail_cnt++; $display("FAIL prio_slot got %0d want 5", SLOT);
      end
   endtask

   task automatic test_abort();
      int h_cnt, dt_low;
      h_cnt = 0; dt_low = 0;
      rd_h = 16'h1100; rd_l = 16'h0022;
      @(posedge CLK);
      #1;
      CPU_ADDR = 3'd1; CPU_RNW = 1'b1; CPU_UDSn = 1'b0; CPU_LDSn = 1'b0;
      GP9001_SEL = 1'b1; OBJBANK_SEL = 1'b0;
      for (int n = 1; n <= 14; n++) begin
         @(posedge CLK);
         @(negedge CLK);
         h_cnt  += int'(op_rh);
         dt_low += int'(!CPU_DTACKn);
         if (n == 2) idle_bus();
      end
      cmp_cnt++;
      if (h_cnt !== 2) begin
         fail_cnt++; $display("FAIL abort_gcu_done got %0d want 2", h_cnt);
      end
      cmp_cnt++;
      if (dt_low !== 0 || GP9001CS !== 1'b0) begin
         fail_cnt++;
         $display("FAIL abort_no_dtack got dt=%0d cs=%b want 0 0",
                  dt_low, GP9001CS);
      end
      run_access(3'd2, 1'b0, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (dt_cyc !== 5 || stb_cyc[0] !== 2) begin
         fail_cnt++;
         $display("FAIL abort_next got dt=%0d sel=%0d want 5 2",
                  dt_cyc, stb_cyc[0]);
      end
   endtask

   task automatic test_reset_midop();
      ack_en = 1'b0;
      @(posedge CLK);
      #1;
      CPU_ADDR = 3'd3; CPU_RNW = 1'b0; CPU_UDSn = 1'b0; CPU_LDSn = 1'b0;
      CPU_DIN = 16'h0055; GP9001_SEL = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      cmp_cnt++;
      if (GP9001CS !== 1'b1 || op_wreg !== 1'b1) begin
         fail_cnt++;
         $display("FAIL midop_busy got cs=%b wreg=%b want 1 1",
                  GP9001CS, op_wreg);
      end
      RESET = 1'b1;
      #1;
      cmp_cnt++;
      if (GP9001CS !== 1'b0 || stb !== 7'h00 || CPU_DTACKn !== 1'b1 ||
          GP9001DIN !== 16'h0000) begin
         fail_cnt++;
         $display("FAIL midop_async got cs=%b stb=%h dt=%b din=%h want 0 00 1 0000",
                  GP9001CS, stb, CPU_DTACKn, GP9001DIN);
      end
      idle_bus();
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      ack_en = 1'b1;
      run_access(3'd2, 1'b0, 1'b0, 1'b0, 16'h0007, 1'b1, 1'b0, 12);
      cmp_cnt++;
      if (dt_cyc !== 5 || stb_cyc[0] !== 2 || GP9001DIN !== 16'h0007) begin
         fail_cnt++;
         $display("FAIL midop_recover got dt=%0d sel=%0d din=%h want 5 2 0007",
                  dt_cyc, stb_cyc[0], GP9001DIN);
      end
   endtask

`ifdef BAKRAID_GP9001_TIMEOUT_EN
   task automatic test_timeout();
      ack_en = 1'b0;
      run_access(3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 400);
      ack_en = 1'b1;
      cmp_cnt++;
      if (dt_cyc < 0 || dout_dt !== 16'hFFFF) begin
         fail_cnt++;
         $display("FAIL timeout got dt=%0d dout=%h want dtack ffff",
                  dt_cyc, dout_dt);
      end
   endtask
`endif

   initial begin
      RESET = 1'b1;
      idle_bus();
      CPU_ADDR = '0; CPU_DIN = '0;
      CPU_HSYNC = 1'b0; CPU_VSYNC = 1'b0; CPU_FBLANK = 1'b0;
      GP9001ACK = 1'b0; GP9001DOUT = '0;
      repeat (3) @(posedge CLK);
      test_reset();
      test_write_select_reg();
      test_word_read();
      test_status();
      test_zero_reads();
      test_byte_lanes();
      test_objbank_write();
      test_priority();
      test_abort();
      test_reset_midop();
`ifdef BAKRAID_GP9001_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
